// File: rtl/heap_ram_checker_if.sv
// heap_ram_checker_if: write stream and verdict signals between the
// max-priority-queue (master) and the result RAM / heap checker (slave).
interface heap_ram_checker_if #(
    parameter int AW = 8,
    parameter int DW = 8
);
    logic          RAM_valid;
    logic [AW-1:0] RAM_A;
    logic [DW-1:0] RAM_D;
    logic          done;
    logic          chk_busy;
    logic          check_done;
    logic          heap_ok;
    logic [AW-1:0] err_idx;
    logic [AW:0]   count;
    logic          wr_drop;
    logic          dup_wr;

    modport master (
        output RAM_valid, RAM_A, RAM_D, done,
        input  chk_busy, check_done, heap_ok, err_idx, count, wr_drop, dup_wr
    );

    modport slave (
        input  RAM_valid, RAM_A, RAM_D, done,
        output chk_busy, check_done, heap_ok, err_idx, count, wr_drop, dup_wr
    );
endinterface

// File: rtl/heap_ram_checker.sv
// heap_ram_checker: captures the queue's RAM write stream into a private
// memory and, on a rising edge of done, scans it for the max-heap property
// (each child <= its parent), reporting pass/fail and the first bad index.
// Optional feature: define HEAP_CHK_DUPWR_EN to flag addresses written twice
// in one session (dup_wr); otherwise dup_wr is tied to 0.
module heap_ram_checker #(
    parameter int AW = 8,
    parameter int DW = 8
) (
    input logic               clk,
    input logic               rst,
    input logic               clr,
    heap_ram_checker_if.slave bus
);
    typedef enum logic [1:0] {IDLE, CHECK, REPORT} state_t;

    localparam logic [AW:0]   ONE_K = {{AW{1'b0}}, 1'b1};
    localparam logic [AW-1:0] ONE_A = {{(AW-1){1'b0}}, 1'b1};

    logic [DW-1:0] mem [0:2**AW-1];

    state_t        state;
    logic [AW:0]   k;
    logic [AW:0]   count_r;
    logic          done_q;
    logic          chk_busy_r;
    logic          check_done_r;
    logic          heap_ok_r;
    logic          verdict_ok;
    logic [AW-1:0] err_idx_r;
    logic          wr_drop_r;
    logic          dup_wr_r;

    logic          done_rise;
    logic          wr_cap;
    logic [AW:0]   wr_end;
    logic [AW-1:0] k_a;
    logic [AW-1:0] parent_a;
    logic [DW-1:0] child_d;
    logic [DW-1:0] parent_d;

    assign done_rise = bus.done & ~done_q;
    // Writes are only taken while idle; clr discards a same-cycle write.
    assign wr_cap    = bus.RAM_valid && (state == IDLE) && !clr;
    assign wr_end    = {1'b0, bus.RAM_A} + ONE_K;
    // k is only used as an address while k < count <= 2^AW, so truncation is safe.
    assign k_a       = k[AW-1:0];
    assign parent_a  = (k_a - ONE_A) >> 1;
    assign child_d   = mem[k_a];
    assign parent_d  = mem[parent_a];

    // Result memory: data only, never reset; count alone defines validity.
    always_ff @(posedge clk) begin
        if (wr_cap) begin
            mem[bus.RAM_A] <= bus.RAM_D;
        end
    end

    // Control FSM: capture bookkeeping, done edge detect, scan and report.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            k            <= ONE_K;
            count_r      <= '0;
            done_q       <= 1'b1;
            chk_busy_r   <= 1'b0;
            check_done_r <= 1'b0;
            heap_ok_r    <= 1'b0;
            verdict_ok   <= 1'b0;
            err_idx_r    <= '0;
            wr_drop_r    <= 1'b0;
        end else begin
            done_q       <= bus.done;
            check_done_r <= 1'b0;
            if (clr) begin
                state      <= IDLE;
                k          <= ONE_K;
                count_r    <= '0;
                chk_busy_r <= 1'b0;
                heap_ok_r  <= 1'b0;
                err_idx_r  <= '0;
                wr_drop_r  <= 1'b0;
            end else begin
                if (bus.RAM_valid && state != IDLE) begin
                    wr_drop_r <= 1'b1;
                end
                case (state)
                    IDLE: begin
                        if (bus.RAM_valid && wr_end > count_r) begin
                            count_r <= wr_end;
                        end
                        if (done_rise) begin
                            state      <= CHECK;
                            k          <= ONE_K;
                            heap_ok_r  <= 1'b0;
                            err_idx_r  <= '0;
                            chk_busy_r <= 1'b1;
                            verdict_ok <= 1'b1;
                        end
                    end
                    CHECK: begin
                        if (k >= count_r) begin
                            state      <= REPORT;
                            verdict_ok <= 1'b1;
                        end else if (child_d > parent_d) begin
                            state      <= REPORT;
                            verdict_ok <= 1'b0;
                            err_idx_r  <= k_a;
                        end else begin
                            k <= k + ONE_K;
                        end
                    end
                    REPORT: begin
                        check_done_r <= 1'b1;
                        heap_ok_r    <= verdict_ok;
                        chk_busy_r   <= 1'b0;
                        state        <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

`ifdef HEAP_CHK_DUPWR_EN
    logic [2**AW-1:0] wmask;

    // Written-mask per session; a second capture to the same address is sticky.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            wmask    <= '0;
            dup_wr_r <= 1'b0;
        end else if (wr_cap) begin
            if (wmask[bus.RAM_A]) begin
                dup_wr_r <= 1'b1;
            end
            wmask[bus.RAM_A] <= 1'b1;
        end
    end
`else
    assign dup_wr_r = 1'b0;
`endif

    assign bus.chk_busy   = chk_busy_r;
    assign bus.check_done = check_done_r;
    assign bus.heap_ok    = heap_ok_r;
    assign bus.err_idx    = err_idx_r;
    assign bus.count      = count_r;
    assign bus.wr_drop    = wr_drop_r;
    assign bus.dup_wr     = dup_wr_r;
endmodule

// File: tb/tb_heap_ram_checker.sv
// tb_heap_ram_checker: directed stimulus for heap_ram_checker with
// hand-computed expectations for verdict, latency and sticky flags.
module tb_heap_ram_checker;
    localparam int AW = 8;
    localparam int DW = 8;

    logic clk = 1'b0;
    logic rst;
    logic clr;
    int   errors = 0;
    int   checks = 0;

    heap_ram_checker_if #(.AW(AW), .DW(DW)) bus ();

    heap_ram_checker #(.AW(AW), .DW(DW)) dut (
        .clk (clk),
        .rst (rst),
        .clr (clr),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Called and returns at a falling edge.
    task automatic wr(input int a, input int d);
        bus.RAM_valid = 1'b1;
        bus.RAM_A     = a[AW-1:0];
        bus.RAM_D     = d[DW-1:0];
        @(negedge clk);
        bus.RAM_valid = 1'b0;
    endtask

    task automatic do_clr();
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
    endtask

    // Raise done; edge E0 samples it. Record the n for which check_done is
    // high in the cycle after E(n). Optionally inject a write during CHECK.
    task automatic run_check(input string tag, input int exp_edge, input int exp_ok,
                             input int exp_err, input bit inject);
        int   found;
        logic busy0;
        logic busy_at_done;
        found        = -1;
        busy0        = 1'b0;
        busy_at_done = 1'b1;
        bus.done     = 1'b1;
        for (int n = 0; n < 40 && found < 0; n++) begin
            @(posedge clk);
            @(negedge clk);
            if (n == 0) busy0 = bus.chk_busy;
            if (bus.check_done) begin
                found        = n;
                busy_at_done = bus.chk_busy;
            end
            if (inject) begin
                bus.RAM_valid = (n == 1);
                bus.RAM_A     = 8'd1;
                bus.RAM_D     = 8'd100;
            end
        end
        bus.RAM_valid = 1'b0;
        check({tag, "_done_edge"}, found, exp_edge);
        check({tag, "_busy_after_e0"}, busy0, 1);
        check({tag, "_busy_at_done"}, busy_at_done, 0);
        check({tag, "_heap_ok"}, bus.heap_ok, exp_ok);
        check({tag, "_err_idx"}, bus.err_idx, exp_err);
        bus.done = 1'b0;
        @(negedge clk);
        check({tag, "_done_pulse_1cyc"}, bus.check_done, 0);
        check({tag, "_verdict_held"}, bus.heap_ok, exp_ok);
    endtask

    initial begin
        int  seen_done;
        int  seen_busy;
        rst           = 1'b1;
        clr           = 1'b0;
        bus.done      = 1'b1;
        bus.RAM_valid = 1'b0;
        bus.RAM_A     = '0;
        bus.RAM_D     = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Reset state; done held high across reset must not start a check.
        check("rst_chk_busy", bus.chk_busy, 0);
        check("rst_check_done", bus.check_done, 0);
        check("rst_heap_ok", bus.heap_ok, 0);
        check("rst_err_idx", bus.err_idx, 0);
        check("rst_count", bus.count, 0);
        check("rst_wr_drop", bus.wr_drop, 0);
        check("rst_dup_wr", bus.dup_wr, 0);
        repeat (3) @(negedge clk);
        check("rst_done_high_no_start", bus.chk_busy, 0);
        bus.done = 1'b0;
        @(negedge clk);

        // Valid heap [9,7,8,3,5]: pass after E6.
        wr(0, 9); wr(1, 7); wr(2, 8); wr(3, 3); wr(4, 5);
        check("pass_count", bus.count, 5);
        run_check("pass", 6, 1, 0, 1'b0);

        // [9,7,8,3,10]: child 4 (10) > parent 1 (7), fail after E5.
        do_clr();
        wr(0, 9); wr(1, 7); wr(2, 8); wr(3, 3); wr(4, 10);
        run_check("fail4", 5, 0, 4, 1'b0);

        // Empty session: trivial pass after E2.
        do_clr();
        check("empty_count", bus.count, 0);
        run_check("empty", 2, 1, 0, 1'b0);

        // Write during CHECK is dropped (would break heap at index 1).
        do_clr();
        wr(0, 9); wr(1, 7); wr(2, 8); wr(3, 3); wr(4, 5);
        run_check("inject", 6, 1, 0, 1'b1);
        check("inject_wr_drop", bus.wr_drop, 1);
        check("inject_count", bus.count, 5);
        do_clr();
        check("clr_wr_drop", bus.wr_drop, 0);
        check("clr_heap_ok", bus.heap_ok, 0);
        check("clr_err_idx", bus.err_idx, 0);
        check("clr_count", bus.count, 0);
        check("clr_dup_wr", bus.dup_wr, 0);

        // Reset mid-CHECK with done held high: abort, no pulse, no restart.
        wr(0, 9); wr(1, 7); wr(2, 8); wr(3, 3); wr(4, 5);
        bus.done = 1'b1;
        @(posedge clk);
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        check("midrst_busy_before", bus.chk_busy, 1);
        rst = 1'b1;
        @(negedge clk);
        rst       = 1'b0;
        seen_done = 0;
        seen_busy = 0;
        for (int i = 0; i < 10; i++) begin
            if (bus.check_done) seen_done++;
            if (bus.chk_busy) seen_busy++;
            @(negedge clk);
        end
        check("midrst_no_done", seen_done, 0);
        check("midrst_no_restart", seen_busy, 0);
        check("midrst_count", bus.count, 0);
        bus.done = 1'b0;
        @(negedge clk);
        run_check("rerise", 2, 1, 0, 1'b0);

        // Entry beyond the real heap: 5 -> parent 2 (8), 20 > 8, fail at 5.
        do_clr();
        wr(0, 9); wr(1, 7); wr(2, 8); wr(3, 3); wr(5, 20); wr(4, 1);
        check("beyond_count", bus.count, 6);
        run_check("beyond", 6, 0, 5, 1'b0);

        // clr beats a same-cycle write, without wr_drop.
        do_clr();
        clr           = 1'b1;
        bus.RAM_valid = 1'b1;
        bus.RAM_A     = 8'd7;
        bus.RAM_D     = 8'd1;
        @(negedge clk);
        clr           = 1'b0;
        bus.RAM_valid = 1'b0;
        check("clr_vs_wr_count", bus.count, 0);
        check("clr_vs_wr_drop", bus.wr_drop, 0);

        // Duplicate address write.
        wr(3, 1); wr(3, 2);
`ifdef HEAP_CHK_DUPWR_EN
        check("dup_wr", bus.dup_wr, 1);
`else
        check("dup_wr", bus.dup_wr, 0);
`endif
        check("dup_count", bus.count, 4);

        // Top address: count reaches 2^AW without wrapping.
        wr(255, 0);
        check("count_max", bus.count, 256);
        do_clr();
        check("count_max_clr", bus.count, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/heap_ram_checker.md
# heap_ram_checker

Sink stage that sits directly downstream of the max-priority-queue block and consumes its RAM write stream (`RAM_valid`/`RAM_A`/`RAM_D`) into a private result memory. When the queue raises `done`, the block scans the captured image and checks the max-heap property: every child is less than or equal to its parent. It reports pass/fail with the first offending index. It serves as the on-chip result RAM and the self-check point for queue output.

## Interface
Parameters:
- `AW`, 8, address width; memory depth is 2^AW entries.
- `DW`, 8, data width.

Ports:
- `clk`  in  1  clock; all logic on the rising edge.
- `rst`  in  1  reset; one clock; reset is synchronous and active-high.
- `clr`  in  1  synchronous session clear.
- `RAM_valid`  in  1  write strobe from the queue.
- `RAM_A`  in  AW  write address.
- `RAM_D`  in  DW  write data.
- `done`  in  1  queue completion level; its rising edge starts a check.
- `chk_busy`  out  1  high while in CHECK or REPORT.
- `check_done`  out  1  one-cycle pulse when the verdict is valid.
- `heap_ok`  out  1  verdict; held until the next check starts, `clr`, or `rst`.
- `err_idx`  out  AW  first failing child index; 0 on pass.
- `count`  out  AW+1  number of valid entries, computed as max(`RAM_A`+1) over captured writes.
- `wr_drop`  out  1  sticky; a write arrived while `chk_busy` was high.
- `dup_wr`  out  1  sticky; an address was written twice in one session (feature-gated).

## Operation
- States: IDLE, CHECK, REPORT.
- IDLE:
  - A write with `RAM_valid`=1 stores `mem[RAM_A]<=RAM_D`.
  - On the same write, `count<=max(count, RAM_A+1)`, computed in AW+1 bits with no wrap. A write to address 2^AW-1 gives `count`=2^AW.
- Rising-edge detect of `done`: an edge is `done`=1 with `done_q`=0, where `done_q` is the registered copy of `done`.
  - An edge sampled in IDLE moves the block to CHECK with `k<=1` and clears `heap_ok` and `err_idx`.
  - An edge sampled outside IDLE is ignored.
- CHECK, one index per edge:
  - If `k>=count`: go to REPORT with verdict pass.
  - Else if `mem[k] > mem[(k-1)>>1]` (unsigned): go to REPORT with verdict fail and `err_idx<=k`.
  - Else: `k<=k+1`.
  - `k` is AW+1 bits wide.
- REPORT: pulse `check_done`, latch `heap_ok`, then return to IDLE.
- Writes arriving while `chk_busy`=1 are discarded and set `wr_drop`.
- `clr`:
  - Sets `count`, `wr_drop`, `dup_wr`, `heap_ok`, `err_idx` to 0 and the state to IDLE.
  - Memory contents are not erased; `count` alone defines validity.
  - `clr` beats a same-cycle `RAM_valid`, and that write is discarded without setting `wr_drop`.
  - `clr` beats a same-cycle `done` edge.
- Boundary cases:
  - `count`=0 or 1 passes trivially.
  - A write to an index beyond the true heap size extends `count` and is checked.

## Timing
- Write capture: data is readable by the checker on the edge after `RAM_valid` is sampled. Back-to-back writes are accepted every cycle.
- Let E0 be the edge that samples the `done` rise.
  - Pass: `check_done` is high during the cycle after edge E(max(`count`,1)+1).
  - Fail at index k: `check_done` is high after edge E(k+1).
- `chk_busy` rises after E0 and falls in the same cycle `check_done` is high.
- `heap_ok` and `err_idx` are stable from the `check_done` cycle onward.
- Reset values:
  - All outputs are 0.
  - State is IDLE, `k`=1.
  - `done_q` resets to 1, so a `done` still high across reset does not start a check. A fresh rise is required.
- `rst` mid-CHECK: the scan aborts immediately, with no `check_done` pulse.

## Configuration
- `HEAP_CHK_DUPWR_EN` defined:
  - Adds a 2^AW-bit written-mask, cleared by `rst`/`clr`.
  - A captured write to an address whose mask bit is already set raises `dup_wr`, which is sticky.
- Undefined: no mask is built, and `dup_wr` is tied to 0.

## Test plan
- Write [9,7,8,3,5] to addresses 0..4, raise `done` -> `check_done` one cycle after edge E6, `heap_ok`=1, `err_idx`=0, `count`=5.
- Write [9,7,8,3,10] to addresses 0..4, raise `done` -> fail, `err_idx`=4, `check_done` after E5.
- No writes, raise `done` -> `heap_ok`=1 after E2.
- Inject a write during CHECK -> `wr_drop`=1 and verdict unchanged. Then `clr` -> all flags 0 and `count`=0.
- Assert `rst` during CHECK with `done` held high -> no `check_done`, no restart. Drop and re-raise `done` -> a new check runs.
- With `HEAP_CHK_DUPWR_EN` defined, write address 3 twice -> `dup_wr`=1. Without the macro -> `dup_wr`=0.
